// File: rtl/micro_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// micro_sequencer_pkg
//   Shared types for the control-word interface between the micro-sequencer
//   and the datapath. It holds the expanded control word, the packed 14-bit
//   microword layout with its field positions, the sequencer opcodes and the
//   sequencer state encoding.
//
//   It also provides MICRO_INSTRUCTION_WORD_WIDTH (14) when no earlier file
//   has already defined it.
//
//   Ports: none (package).
// -----------------------------------------------------------------------------
`ifndef MICRO_INSTRUCTION_WORD_WIDTH
`define MICRO_INSTRUCTION_WORD_WIDTH 14
`endif

package micro_sequencer_pkg;

   // Memory operation as seen by the memory interface
   typedef enum logic [1:0] {
      MEM_NOP   = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2
   } mem_op_e;

   // Per-register operation (rax..rdx)
   typedef enum logic [1:0] {
      REG_NOP    = 2'd0,
      REG_LOAD   = 2'd1,
      REG_ENABLE = 2'd2,
      REG_RSVD   = 2'd3
   } reg_op_e;

   // Sequencing field of a microword
   typedef enum logic [1:0] {
      SEQ_CONT     = 2'd0,
      SEQ_DISPATCH = 2'd1,
      SEQ_NEXT     = 2'd2,
      SEQ_HALT     = 2'd3
   } seq_op_e;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } seq_state_e;

   // Field positions inside the packed microword (MSB..LSB)
   localparam int UW_ALU_OP_MSB  = 13;
   localparam int UW_ALU_OP_LSB  = 10;
   localparam int UW_ALU_EN_BIT  = 9;
   localparam int UW_MEM_MSB     = 8;
   localparam int UW_MEM_LSB     = 7;
   localparam int UW_BUS_SEL_BIT = 6;
   localparam int UW_REG_SEL_MSB = 5;
   localparam int UW_REG_SEL_LSB = 4;
   localparam int UW_REG_OP_MSB  = 3;
   localparam int UW_REG_OP_LSB  = 2;
   localparam int UW_SEQ_MSB     = 1;
   localparam int UW_SEQ_LSB     = 0;

   // Packed microword, laid out exactly as stored in the microcode ROM
   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_enable;
      logic [1:0] mem;
      logic       bus_selector;
      logic [1:0] reg_sel;
      reg_op_e    reg_op;
      seq_op_e    seq;
   } micro_word_t;

   // Fully expanded control word driving the datapath
   typedef struct packed {
      logic       reset;
      logic [3:0] alu_op;
      logic       alu_enable;
      mem_op_e    memory_op;
      logic       bus_selector;
      logic       data_word_selector;
      reg_op_e    rax_op;
      reg_op_e    rbx_op;
      reg_op_e    rcx_op;
      reg_op_e    rdx_op;
      logic       control_unit_load;
      logic       next_instr;
      logic       halt;
   } control_word_t;

   // Encoding 3 of the mem field is an unused slot and behaves as NOP
   function automatic mem_op_e decode_mem(input logic [1:0] field);
      case (field)
         2'd1:    return MEM_READ;
         2'd2:    return MEM_WRITE;
         default: return MEM_NOP;
      endcase
   endfunction

endpackage

// File: rtl/micro_sequencer_unpack.sv
// -----------------------------------------------------------------------------
// microword_unpack
//   Purely combinational expansion of one packed microword into a
//   control_word_t. It steers reg_op to the register named by reg_sel, maps
//   the mem field (encoding 3 becomes NOP) and derives data_word_selector.
//   The reset bit is left at 0; the sequencer owns reset, stall, step and
//   halt masking.
//
//   Ports:
//     uword   in   microword from the microcode ROM
//     cw_raw  out  unmasked expanded control word
// -----------------------------------------------------------------------------
module microword_unpack
   import micro_sequencer_pkg::*;
(
   input  logic [`MICRO_INSTRUCTION_WORD_WIDTH-1:0] uword,
   output control_word_t                            cw_raw
);

   micro_word_t mw;

   assign mw = micro_word_t'(uword);

   always_comb begin
      cw_raw = '0;
      cw_raw.alu_op             = mw.alu_op;
      cw_raw.alu_enable         = mw.alu_enable;
      cw_raw.memory_op          = decode_mem(mw.mem);
      cw_raw.bus_selector       = mw.bus_selector;
      // Register drives the data bus toward memory only on a write
      cw_raw.data_word_selector = (decode_mem(mw.mem) == MEM_WRITE) &&
                                  (mw.reg_op == REG_ENABLE);
      cw_raw.rax_op             = REG_NOP;
      cw_raw.rbx_op             = REG_NOP;
      cw_raw.rcx_op             = REG_NOP;
      cw_raw.rdx_op             = REG_NOP;
      case (mw.reg_sel)
         2'd0:    cw_raw.rax_op = mw.reg_op;
         2'd1:    cw_raw.rbx_op = mw.reg_op;
         2'd2:    cw_raw.rcx_op = mw.reg_op;
         default: cw_raw.rdx_op = mw.reg_op;
      endcase
      cw_raw.control_unit_load  = (mw.seq == SEQ_DISPATCH);
      cw_raw.next_instr         = (mw.seq == SEQ_NEXT);
      cw_raw.halt               = (mw.seq == SEQ_HALT);
   end

endmodule

// File: rtl/micro_sequencer.sv
// -----------------------------------------------------------------------------
// micro_sequencer
//   Walks the microcode store. It owns the micro-program counter (uPC),
//   dispatches on the instruction opcode, stalls while memory is busy and
//   halts. Each microword is decoded with zero cycles of latency from the
//   registered uPC, and the uPC moves one cycle after the word that issued.
//
//   Optional feature: MICRO_SEQUENCER_STEP_EN adds a 'step' input. In RUN a
//   word issues only on cycles where step=1. On step=0 cycles cw is all NOP
//   and the uPC holds.
//
//   Ports:
//     clk        in   clock
//     rst        in   synchronous active-high reset
//     step       in   single-step enable (only with MICRO_SEQUENCER_STEP_EN)
//     uaddr      out  microcode ROM address (= uPC)
//     uword      in   microword read asynchronously at uaddr
//     opcode     in   current instruction opcode used for dispatch
//     mem_ready  in   memory has completed the requested READ/WRITE
//     cw         out  expanded control word
//     halted     out  sequencer is in HALTED
// -----------------------------------------------------------------------------
module micro_sequencer
   import micro_sequencer_pkg::*;
#(
   parameter  int OPCODE_W  = 6,
   parameter  int SLOT_LOG2 = 2,
   localparam int UPC_W     = OPCODE_W + SLOT_LOG2
) (
   input  logic                                     clk,
   input  logic                                     rst,
`ifdef MICRO_SEQUENCER_STEP_EN
   input  logic                                     step,
`endif
   output logic [UPC_W-1:0]                         uaddr,
   input  logic [`MICRO_INSTRUCTION_WORD_WIDTH-1:0] uword,
   input  logic [OPCODE_W-1:0]                      opcode,
   input  logic                                     mem_ready,
   output control_word_t                            cw,
   output logic                                     halted
);

   seq_state_e    state;
   logic [UPC_W-1:0] upc;
   control_word_t cw_raw;
   logic          issue;
   logic          stall;

   microword_unpack u_unpack (
      .uword  (uword),
      .cw_raw (cw_raw)
   );

`ifdef MICRO_SEQUENCER_STEP_EN
   assign issue = step;
`else
   assign issue = 1'b1;
`endif

   // cw_raw.memory_op already maps encoding 3 to NOP, so that case never stalls
   assign stall  = issue && (cw_raw.memory_op != MEM_NOP) && !mem_ready;
   assign uaddr  = upc;
   assign halted = (state == HALTED) && !rst;

   // While stalled, a register keeps driving the bus but does not capture
   function automatic reg_op_e stall_reg_op(input reg_op_e op);
      return (op == REG_ENABLE) ? REG_ENABLE : REG_NOP;
   endfunction

   always_comb begin
      cw = '0;
      if (rst) begin
         cw = '0;
      end else if (state == HALTED) begin
         cw.halt = 1'b1;
      end else if (issue) begin
         cw = cw_raw;
         if (stall) begin
            cw.alu_enable        = 1'b0;
            cw.rax_op            = stall_reg_op(cw_raw.rax_op);
            cw.rbx_op            = stall_reg_op(cw_raw.rbx_op);
            cw.rcx_op            = stall_reg_op(cw_raw.rcx_op);
            cw.rdx_op            = stall_reg_op(cw_raw.rdx_op);
            cw.control_unit_load = 1'b0;
            cw.next_instr        = 1'b0;
            cw.halt              = 1'b0;
         end
      end
      cw.reset = rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         upc   <= '0;
         state <= RUN;
      end else begin
         case (state)
            RUN: begin
               if (issue && !stall) begin
                  if (cw_raw.halt) begin
                     state <= HALTED;
                  end else if (cw_raw.control_unit_load) begin
                     upc <= {opcode, {SLOT_LOG2{1'b0}}};
                  end else if (cw_raw.next_instr) begin
                     upc <= '0;
                  end else begin
                     upc <= upc + UPC_W'(1);
                  end
               end
            end
            default: begin
               state <= HALTED;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// -----------------------------------------------------------------------------
// tb_micro_sequencer
//   Directed self-checking bench for micro_sequencer. The bench drives the
//   microword directly, standing in for the ROM, and checks the expanded
//   control word, uaddr and halted against hand-computed values.
// -----------------------------------------------------------------------------
module tb_micro_sequencer;
   import micro_sequencer_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    uaddr;
   logic [13:0]   uword;
   logic [5:0]    opcode;
   logic          mem_ready;
   control_word_t cw;
   logic          halted;
`ifdef MICRO_SEQUENCER_STEP_EN
   logic          step;
`endif

   int checks   = 0;
   int failures = 0;

   control_word_t exp_cw;

   always #5 clk = ~clk;

   micro_sequencer dut (
      .clk       (clk),
      .rst       (rst),
`ifdef MICRO_SEQUENCER_STEP_EN
      .step      (step),
`endif
      .uaddr     (uaddr),
      .uword     (uword),
      .opcode    (opcode),
      .mem_ready (mem_ready),
      .cw        (cw),
      .halted    (halted)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      uword     = 14'h614;
      opcode    = 6'h00;
      mem_ready = 1'b1;
`ifdef MICRO_SEQUENCER_STEP_EN
      step      = 1'b1;
`endif
      tick;
      tick;
      #1;
      exp_cw       = '0;
      exp_cw.reset = 1'b1;
      chk("reset_cw", cw, exp_cw);
      chk("reset_uaddr", uaddr, 8'h00);
      chk("reset_halted", halted, 1'b0);

      // Release: 0x614 = ADD, alu_enable, rbx LOAD, CONT
      rst = 1'b0;
      #1;
      chk("run_alu_op", cw.alu_op, 4'h1);
      chk("run_alu_en", cw.alu_enable, 1'b1);
      chk("run_rbx_op", cw.rbx_op, REG_LOAD);
      chk("run_rax_op", cw.rax_op, REG_NOP);
      chk("run_rcx_op", cw.rcx_op, REG_NOP);
      chk("run_rdx_op", cw.rdx_op, REG_NOP);
      chk("run_reset", cw.reset, 1'b0);
      tick;
      chk("cont_uaddr", uaddr, 8'h01);

      // Dispatch on opcode 5
      uword  = 14'h001;
      opcode = 6'h05;
      #1;
      chk("dispatch_load", cw.control_unit_load, 1'b1);
      tick;
      chk("dispatch_uaddr", uaddr, 8'h14);

      // READ into rax with memory not ready for three cycles
      uword     = 14'h084;
      mem_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_mem_op", cw.memory_op, MEM_READ);
         chk("stall_rax_op", cw.rax_op, REG_NOP);
         chk("stall_uaddr", uaddr, 8'h14);
         tick;
      end
      mem_ready = 1'b1;
      #1;
      chk("ready_rax_op", cw.rax_op, REG_LOAD);
      tick;
      chk("ready_uaddr", uaddr, 8'h15);

      // WRITE from rcx (ENABLE) with alu_enable, stalled for one cycle
      uword     = 14'h328;
      mem_ready = 1'b0;
      #1;
      chk("wstall_dws", cw.data_word_selector, 1'b1);
      chk("wstall_rcx_op", cw.rcx_op, REG_ENABLE);
      chk("wstall_alu_en", cw.alu_enable, 1'b0);
      chk("wstall_mem_op", cw.memory_op, MEM_WRITE);
      tick;
      chk("wstall_uaddr", uaddr, 8'h15);
      mem_ready = 1'b1;
      #1;
      chk("wready_alu_en", cw.alu_enable, 1'b1);
      tick;
      chk("wready_uaddr", uaddr, 8'h16);

      // mem=3 never stalls; seq=NEXT returns to 0
      uword     = 14'h182;
      mem_ready = 1'b0;
      #1;
      chk("mem3_mem_op", cw.memory_op, MEM_NOP);
      chk("next_instr", cw.next_instr, 1'b1);
      tick;
      chk("next_uaddr", uaddr, 8'h00);

      // Wrap: dispatch to 0xFC, count up to 0xFF, then wrap to 0
      mem_ready = 1'b1;
      uword     = 14'h001;
      opcode    = 6'h3F;
      tick;
      chk("wrap_dispatch", uaddr, 8'hFC);
      uword = 14'h000;
      tick;
      tick;
      tick;
      chk("wrap_ff", uaddr, 8'hFF);
      tick;
      chk("wrap_zero", uaddr, 8'h00);
      tick;
      chk("pre_halt_uaddr", uaddr, 8'h01);

      // Halt
      uword = 14'h003;
      #1;
      chk("halt_word", cw.halt, 1'b1);
      chk("halt_not_yet", halted, 1'b0);
      tick;
      chk("halted_flag", halted, 1'b1);
      uword = 14'h614;
      #1;
      exp_cw      = '0;
      exp_cw.halt = 1'b1;
      chk("halted_cw", cw, exp_cw);
      for (int i = 0; i < 10; i++) begin
         uword = (i % 2 == 0) ? 14'h001 : 14'h182;
         tick;
      end
      chk("halted_uaddr", uaddr, 8'h01);
      chk("halted_flag_hold", halted, 1'b1);
      chk("halted_cw_hold", cw, exp_cw);

      // Reset pulse out of HALTED
      rst = 1'b1;
      #1;
      exp_cw       = '0;
      exp_cw.reset = 1'b1;
      chk("halt_rst_halted", halted, 1'b0);
      chk("halt_rst_cw", cw, exp_cw);
      tick;
      chk("halt_rst_uaddr", uaddr, 8'h00);
      rst   = 1'b0;
      uword = 14'h614;
      #1;
      chk("after_rst_alu_en", cw.alu_enable, 1'b1);
      chk("after_rst_halted", halted, 1'b0);
      tick;
      chk("after_rst_uaddr", uaddr, 8'h01);

      // Reset in the middle of a stall leaves nothing pending
      uword     = 14'h084;
      mem_ready = 1'b0;
      tick;
      chk("midstall_uaddr", uaddr, 8'h01);
      rst = 1'b1;
      tick;
      rst   = 1'b0;
      uword = 14'h000;
      #1;
      chk("midstall_rst_mem", cw.memory_op, MEM_NOP);
      chk("midstall_rst_uaddr", uaddr, 8'h00);
      tick;
      chk("midstall_cont", uaddr, 8'h01);
      mem_ready = 1'b1;

`ifdef MICRO_SEQUENCER_STEP_EN
      // Single-step: step=0 holds everything and emits NOP
      uword  = 14'h614;
      step   = 1'b0;
      exp_cw = '0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("step0_cw", cw, exp_cw);
         tick;
         chk("step0_uaddr", uaddr, 8'h01);
      end
      step = 1'b1;
      #1;
      chk("step1_alu_en", cw.alu_enable, 1'b1);
      chk("step1_rbx_op", cw.rbx_op, REG_LOAD);
      tick;
      chk("step1_uaddr", uaddr, 8'h02);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
